// File: rtl/conv3x3_frame_ctrl_pkg.sv
// Shared types and defaults for the 3x3 convolution frame sequencer.
// Holds the FSM encoding, pixel/counter defaults and kernel mode codes.
package conv3x3_frame_ctrl_pkg;

    localparam int DEF_PIX_W     = 24;
    localparam int DEF_MAX_WIDTH = 640;
    localparam int DEF_CNT_W     = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        KM_SHARPEN  = 2'b00,
        KM_STRONG   = 2'b01,
        KM_IDENTITY = 2'b10,
        KM_CUSTOM   = 2'b11
    } kmode_t;

endpackage

// File: rtl/conv3x3_frame_ctrl_line_buffer_2row.sv
// Two line RAMs delaying the pixel stream by one and two lines.
// Read-before-write at the current column; advances on i_en.
module line_buffer_2row
    import conv3x3_frame_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_WIDTH,
    parameter int PIX_W = DEF_PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_pix,
    output logic [PIX_W-1:0] o_row1,
    output logic [PIX_W-1:0] o_row2
);

    logic [PIX_W-1:0] r_ram1 [DEPTH];
    logic [PIX_W-1:0] r_ram2 [DEPTH];

    assign o_row1 = r_ram1[i_addr];
    assign o_row2 = r_ram2[i_addr];

    // Row y-1 cascades into row y-2 as the new pixel lands
    always_ff @(posedge iClk) begin
        if (i_en) begin
            r_ram1[i_addr] <= i_pix;
            r_ram2[i_addr] <= r_ram1[i_addr];
        end
    end

endmodule

// File: rtl/conv3x3_frame_ctrl.sv
// Frame sequencer: raster stream in, 3x3 windows to the convolution,
// results out on a valid/ready stream with last/done signalling.
module conv3x3_frame_ctrl
    import conv3x3_frame_ctrl_pkg::*;
#(
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PIX_W     = DEF_PIX_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_cfg_width,
    input  logic [CNT_W-1:0]   i_cfg_height,
    input  logic [31:0]        i_reg0,
    input  logic [31:0]        i_reg1,
    input  logic [31:0]        i_reg2,
    input  logic [31:0]        i_reg3,
    output logic [31:0]        o_kreg0,
    output logic [31:0]        o_kreg1,
    output logic [31:0]        o_kreg2,
    output logic [31:0]        o_kreg3,
    input  logic [PIX_W-1:0]   s_pixel,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [9*PIX_W-1:0] o_win,
    output logic               o_conv_enable,
    output logic               o_conv_clk_en,
    input  logic [PIX_W-1:0]   i_conv_rgb,
    input  logic               i_conv_valid,
    output logic [PIX_W-1:0]   m_rgb,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam logic [CNT_W-1:0] L_MAXW = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] L_THR  = CNT_W'(3);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_height;
    logic [31:0]      r_kreg0;
    logic [31:0]      r_kreg1;
    logic [31:0]      r_kreg2;
    logic [31:0]      r_kreg3;
    logic             r_err;
    logic             r_en;
    logic             r_last;
    logic             r_last_q;

    logic [PIX_W-1:0] r_top [3];
    logic [PIX_W-1:0] r_mid [3];
    logic [PIX_W-1:0] r_bot [3];

    logic             w_clk_en;
    logic             w_busy;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_cfg_bad;
    logic             w_x_end;
    logic             w_y_end;
    logic             w_win_ok;
    logic [PIX_W-1:0] w_row1;
    logic [PIX_W-1:0] w_row2;

    assign w_clk_en  = ~(i_conv_valid & ~m_ready);
    assign w_busy    = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign w_accept  = s_valid & s_ready;
    assign w_x_end   = (r_x == r_width - L_ONE);
    assign w_y_end   = (r_y == r_height - L_ONE);
    assign w_win_ok  = (r_x >= L_TWO) & (r_y >= L_TWO);
    assign w_cfg_bad = (i_cfg_width < L_THR)
                     | (i_cfg_height < L_THR)
                     | (i_cfg_width > L_MAXW);

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        s_ready     = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start && !w_cfg_bad) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = w_clk_en;
                if (s_valid && w_clk_en && w_x_end && w_y_end)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_conv_valid && m_ready && r_last_q)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Shadows are captured on any start in IDLE, good config or not
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_width  <= '0;
            r_height <= '0;
            r_kreg0  <= '0;
            r_kreg1  <= '0;
            r_kreg2  <= '0;
            r_kreg3  <= '0;
            r_err    <= 1'b0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_width  <= i_cfg_width;
            r_height <= i_cfg_height;
            r_kreg0  <= i_reg0;
            r_kreg1  <= i_reg1;
            r_kreg2  <= i_reg2;
            r_kreg3  <= i_reg3;
            r_err    <= w_cfg_bad;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_en     <= 1'b0;
            r_last   <= 1'b0;
            r_last_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_top[i] <= '0;
                r_mid[i] <= '0;
                r_bot[i] <= '0;
            end
        end else begin
            if (w_start_ok) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_accept) begin
                if (w_x_end) begin
                    r_x <= '0;
                    r_y <= r_y + L_ONE;
                end else begin
                    r_x <= r_x + L_ONE;
                end
            end
            if (w_accept) begin
                r_top[2] <= w_row2;
                r_mid[2] <= w_row1;
                r_bot[2] <= s_pixel;
                // Older columns start empty on each new line
                if (r_x == '0) begin
                    r_top[1] <= '0;
                    r_mid[1] <= '0;
                    r_bot[1] <= '0;
                    r_top[0] <= '0;
                    r_mid[0] <= '0;
                    r_bot[0] <= '0;
                end else begin
                    r_top[1] <= r_top[2];
                    r_mid[1] <= r_mid[2];
                    r_bot[1] <= r_bot[2];
                    r_top[0] <= r_top[1];
                    r_mid[0] <= r_mid[1];
                    r_bot[0] <= r_bot[1];
                end
            end
            // r_last_q mirrors the convolution's own output register
            if (w_clk_en) begin
                r_en     <= w_accept & w_win_ok;
                r_last   <= w_accept & w_x_end & w_y_end;
                r_last_q <= r_en & r_last;
            end
        end
    end

    line_buffer_2row #(
        .DEPTH (MAX_WIDTH),
        .PIX_W (PIX_W),
        .AW    (AW)
    ) u_lbuf (
        .iClk   (iClk),
        .i_en   (w_accept),
        .i_addr (r_x[AW-1:0]),
        .i_pix  (s_pixel),
        .o_row1 (w_row1),
        .o_row2 (w_row2)
    );

    assign o_win = {r_top[0], r_top[1], r_top[2],
                    r_mid[0], r_mid[1], r_mid[2],
                    r_bot[0], r_bot[1], r_bot[2]};

    assign o_kreg0       = r_kreg0;
    assign o_kreg1       = r_kreg1;
    assign o_kreg2       = r_kreg2;
    assign o_kreg3       = r_kreg3;
    assign o_conv_enable = r_en;
    assign o_conv_clk_en = w_clk_en;
    assign m_rgb         = i_conv_rgb;
    assign m_valid       = i_conv_valid & w_busy;
    assign m_last        = r_last_q & m_valid;
    assign o_busy        = w_busy;
    assign o_err         = r_err;

endmodule

// File: tb/tb_conv3x3_frame_ctrl.sv
// Directed bench for conv3x3_frame_ctrl with an identity-kernel
// convolution stand-in (one register stage, centre pixel out).
module tb_conv3x3_frame_ctrl;
    import conv3x3_frame_ctrl_pkg::*;

    localparam int MAXW = 640;
    localparam int CW   = 11;
    localparam int PW   = 24;

    logic            iClk = 1'b0;
    logic            iRst;
    logic            i_start;
    logic [CW-1:0]   i_cfg_width;
    logic [CW-1:0]   i_cfg_height;
    logic [31:0]     i_reg0, i_reg1, i_reg2, i_reg3;
    logic [31:0]     o_kreg0, o_kreg1, o_kreg2, o_kreg3;
    logic [PW-1:0]   s_pixel;
    logic            s_valid;
    logic            s_ready;
    logic [9*PW-1:0] o_win;
    logic            o_conv_enable;
    logic            o_conv_clk_en;
    logic [PW-1:0]   cv_rgb;
    logic            cv_valid;
    logic [PW-1:0]   m_rgb;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic            o_busy;
    logic            o_done;
    logic            o_err;

    always #5 iClk = ~iClk;

    conv3x3_frame_ctrl #(
        .MAX_WIDTH (MAXW),
        .CNT_W     (CW),
        .PIX_W     (PW)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .i_start       (i_start),
        .i_cfg_width   (i_cfg_width),
        .i_cfg_height  (i_cfg_height),
        .i_reg0        (i_reg0),
        .i_reg1        (i_reg1),
        .i_reg2        (i_reg2),
        .i_reg3        (i_reg3),
        .o_kreg0       (o_kreg0),
        .o_kreg1       (o_kreg1),
        .o_kreg2       (o_kreg2),
        .o_kreg3       (o_kreg3),
        .s_pixel       (s_pixel),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .o_win         (o_win),
        .o_conv_enable (o_conv_enable),
        .o_conv_clk_en (o_conv_clk_en),
        .i_conv_rgb    (cv_rgb),
        .i_conv_valid  (cv_valid),
        .m_rgb         (m_rgb),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    // Convolution stand-in: identity kernel, held by clk_en
    always @(posedge iClk) begin
        if (iRst) begin
            cv_valid <= 1'b0;
            cv_rgb   <= '0;
        end else if (o_conv_clk_en) begin
            cv_valid <= o_conv_enable;
            cv_rgb   <= o_win[4*PW +: PW];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    logic [PW-1:0] q_rgb[$];
    bit          q_last[$];
    int          last_hs_cyc;
    int          done_cyc;
    int          done_cnt = 0;
    int          stall_cyc = 0;
    int          stall_bad = 0;

    always @(negedge iClk) begin
        cyc++;
        if (m_valid && m_ready) begin
            q_rgb.push_back(m_rgb);
            q_last.push_back(m_last);
            if (m_last) last_hs_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!o_conv_clk_en) begin
            stall_cyc++;
            if (s_ready) stall_bad++;
        end
    end

    bit rdy_tog = 1'b0;
    int rk = 0;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge iClk);
            #1;
            if (rdy_tog) begin
                m_ready = (rk % 4 == 0) || (rk % 4 == 3);
                rk++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [PW-1:0] pix(input int idx);
        logic [31:0] t;
        t = idx * 32'h010101;
        return t[PW-1:0];
    endfunction

    task automatic start(input int w, input int h);
        i_cfg_width  = CW'(w);
        i_cfg_height = CW'(h);
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic feed(input int from, input int to, input bit gaps);
        bit acc;
        int guard;
        for (int i = from; i <= to; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            s_pixel = pix(i);
            s_valid = 1'b1;
            acc     = 1'b0;
            guard   = 0;
            while (!acc && guard < 200) begin
                @(negedge iClk);
                acc = s_ready;
                tick();
                guard++;
            end
            s_valid = 1'b0;
            if (!acc) begin
                chk($sformatf("feed_timeout_px%0d", i), 0, 1);
                return;
            end
        end
    endtask

    task automatic clear_q();
        q_rgb.delete();
        q_last.delete();
        last_hs_cyc = -100;
        done_cyc    = -200;
    endtask

    task automatic check_frame(input string tag, input int w,
                               input int h, input int d0);
        int n;
        int xx;
        int yy;
        for (int g = 0; g < 5000 && done_cnt == d0; g++) tick();
        tick();
        tick();
        chk({tag, "_done_cnt"}, done_cnt, d0 + 1);
        chk({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
        chk({tag, "_busy"}, o_busy, 0);
        n = (w - 2) * (h - 2);
        chk({tag, "_count"}, q_rgb.size(), n);
        for (int k = 0; k < n && k < q_rgb.size(); k++) begin
            yy = 2 + k / (w - 2);
            xx = 2 + k % (w - 2);
            chk($sformatf("%s_val%0d", tag, k), q_rgb[k],
                pix((yy - 1) * w + xx - 1));
            chk($sformatf("%s_last%0d", tag, k), q_last[k],
                (k == n - 1) ? 1 : 0);
        end
    endtask

    int d0;

    initial begin
        iRst         = 1'b1;
        i_start      = 1'b0;
        i_cfg_width  = '0;
        i_cfg_height = '0;
        i_reg0       = 32'h0000_0002;
        i_reg1       = 32'h1111_1111;
        i_reg2       = 32'h2222_2222;
        i_reg3       = 32'h3333_3333;
        s_pixel      = '0;
        s_valid      = 1'b0;
        repeat (3) tick();
        iRst = 1'b0;

        @(negedge iClk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_conv_en", o_conv_enable, 0);
        chk("rst_clk_en", o_conv_clk_en, 1);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_kreg0", o_kreg0, 0);
        chk("rst_kreg3", o_kreg3, 0);
        tick();

        // 4x4, identity, downstream always ready
        clear_q();
        d0 = done_cnt;
        start(4, 4);
        chk("t1_busy", o_busy, 1);
        chk("t1_kreg0", o_kreg0, 32'h2);
        chk("t1_kreg1", o_kreg1, 32'h1111_1111);
        feed(0, 15, 1'b0);
        check_frame("t1", 4, 4, d0);

        // Same frame with downstream back-pressure
        clear_q();
        stall_cyc = 0;
        stall_bad = 0;
        rk        = 0;
        rdy_tog   = 1'b1;
        d0        = done_cnt;
        start(4, 4);
        feed(0, 15, 1'b0);
        check_frame("t2", 4, 4, d0);
        rdy_tog = 1'b0;
        chk("t2_stall_ready", stall_bad, 0);
        chk("t2_stall_seen", stall_cyc > 0, 1);

        // Bad width, then a good 5x5
        start(2, 4);
        tick();
        @(negedge iClk);
        chk("t3_err", o_err, 1);
        chk("t3_busy", o_busy, 0);
        chk("t3_s_ready", s_ready, 0);
        tick();
        clear_q();
        d0 = done_cnt;
        start(5, 5);
        @(negedge iClk);
        chk("t3_err_clr", o_err, 0);
        chk("t3_busy_go", o_busy, 1);
        tick();
        feed(0, 24, 1'b0);
        check_frame("t3", 5, 5, d0);

        // Live kernel register changes mid-frame
        i_reg0 = 32'h2;
        clear_q();
        d0 = done_cnt;
        start(4, 4);
        feed(0, 5, 1'b0);
        i_reg0 = 32'h0;
        tick();
        @(negedge iClk);
        chk("t4_kreg_mid", o_kreg0, 32'h2);
        tick();
        feed(6, 15, 1'b0);
        check_frame("t4", 4, 4, d0);
        chk("t4_kreg_end", o_kreg0, 32'h2);
        clear_q();
        d0 = done_cnt;
        start(3, 3);
        chk("t4_kreg_new", o_kreg0, 32'h0);
        feed(0, 8, 1'b0);
        check_frame("t4b", 3, 3, d0);

        // Reset while a window is in flight
        i_reg0 = 32'h2;
        start(4, 4);
        feed(0, 10, 1'b0);
        iRst = 1'b1;
        tick();
        @(negedge iClk);
        chk("t5_busy", o_busy, 0);
        chk("t5_s_ready", s_ready, 0);
        chk("t5_conv_en", o_conv_enable, 0);
        chk("t5_kreg0", o_kreg0, 0);
        tick();
        iRst = 1'b0;
        tick();
        clear_q();
        d0 = done_cnt;
        start(3, 3);
        feed(0, 8, 1'b0);
        check_frame("t5", 3, 3, d0);

        // Full-width lines with random input gaps
        clear_q();
        d0 = done_cnt;
        start(MAXW, 3);
        chk("t6_busy", o_busy, 1);
        feed(0, 3 * MAXW - 1, 1'b1);
        check_frame("t6", MAXW, 3, d0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
